// File: rtl/cond_wb_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cond_wb_pipe_if : execute-side bus of the conditional writeback unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface cond_wb_pipe_if #(
  parameter int OPW = 4
);
  logic           adv;
  logic           flush;
  logic           ex_valid;
  logic [OPW-1:0] ex_opcode;
  logic [1:0]     ex_funct;
  logic           ex_wb_in;
  logic           ex_c_wr;
  logic           ex_z_wr;
  logic           ex_c_new;
  logic           ex_z_new;
  logic           ex_wb_out;
  logic           eff_c;
  logic           eff_z;
  logic           cm_valid;
  logic           cm_wb;
  logic           c_flag;
  logic           z_flag;

  modport master (
    output adv, flush, ex_valid, ex_opcode, ex_funct, ex_wb_in,
           ex_c_wr, ex_z_wr, ex_c_new, ex_z_new,
    input  ex_wb_out, eff_c, eff_z, cm_valid, cm_wb, c_flag, z_flag
  );

  modport slave (
    input  adv, flush, ex_valid, ex_opcode, ex_funct, ex_wb_in,
           ex_c_wr, ex_z_wr, ex_c_new, ex_z_new,
    output ex_wb_out, eff_c, eff_z, cm_valid, cm_wb, c_flag, z_flag
  );
endinterface
`default_nettype wire

// File: rtl/cond_wb_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cond_wb_pipe : C/Z flag tracking, forwarding and conditional-writeback squash
// Rev 1.0
// ---------------------------------------------------------------------------
module cond_wb_pipe #(
  parameter int             OPW     = 4,
  parameter int             DEPTH   = 3,
  parameter logic [OPW-1:0] ADD_OP  = 4'b0000,
  parameter logic [OPW-1:0] NAND_OP = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  cond_wb_pipe_if.slave     bus
);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_wb;
  logic [DEPTH-1:0] r_cw;
  logic [DEPTH-1:0] r_zw;
  logic [DEPTH-1:0] r_c;
  logic [DEPTH-1:0] r_z;
  logic             r_c_flag;
  logic             r_z_flag;

  logic w_eff_c;
  logic w_eff_z;
  logic w_family;
  logic w_sel;
  logic w_wb_out;
  logic w_cap_cw;
  logic w_cap_zw;

  // Walk oldest to youngest so the youngest pending writer overrides.
  always_comb begin
    w_eff_c = r_c_flag;
    w_eff_z = r_z_flag;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_v[i] && r_cw[i]) w_eff_c = r_c[i];
      if (r_v[i] && r_zw[i]) w_eff_z = r_z[i];
    end
  end

  always_comb begin
    w_family = (bus.ex_opcode == ADD_OP) || (bus.ex_opcode == NAND_OP);
    w_sel    = w_family &&
               (((bus.ex_funct == 2'b10) && !w_eff_c) ||
                ((bus.ex_funct == 2'b01) && !w_eff_z));
    w_wb_out = bus.ex_valid & bus.ex_wb_in & ~w_sel;
    w_cap_cw = bus.ex_valid & bus.ex_c_wr  & ~w_sel;
    w_cap_zw = bus.ex_valid & bus.ex_z_wr  & ~w_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v      <= '0;
      r_wb     <= '0;
      r_cw     <= '0;
      r_zw     <= '0;
      r_c      <= '0;
      r_z      <= '0;
      r_c_flag <= 1'b0;
      r_z_flag <= 1'b0;
    end else if (bus.adv) begin
      if (r_v[DEPTH-1]) begin
        if (r_cw[DEPTH-1]) r_c_flag <= r_c[DEPTH-1];
        if (r_zw[DEPTH-1]) r_z_flag <= r_z[DEPTH-1];
      end
      // A flushed slot shifts forward as a bubble.
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i]  <= r_v[i-1]  & ~bus.flush;
        r_wb[i] <= r_wb[i-1] & ~bus.flush;
        r_cw[i] <= r_cw[i-1];
        r_zw[i] <= r_zw[i-1];
        r_c[i]  <= r_c[i-1];
        r_z[i]  <= r_z[i-1];
      end
      r_v[0]  <= bus.ex_valid & ~bus.flush;
      r_wb[0] <= w_wb_out     & ~bus.flush;
      r_cw[0] <= w_cap_cw     & ~bus.flush;
      r_zw[0] <= w_cap_zw     & ~bus.flush;
      r_c[0]  <= bus.ex_c_new;
      r_z[0]  <= bus.ex_z_new;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_v[i]  <= 1'b0;
        r_wb[i] <= 1'b0;
      end
    end
  end

  assign bus.ex_wb_out = w_wb_out;
  assign bus.eff_c     = w_eff_c;
  assign bus.eff_z     = w_eff_z;
  assign bus.cm_valid  = r_v[DEPTH-1];
  assign bus.cm_wb     = r_v[DEPTH-1] & r_wb[DEPTH-1];
  assign bus.c_flag    = r_c_flag;
  assign bus.z_flag    = r_z_flag;

endmodule
`default_nettype wire

// File: tb/tb_cond_wb_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cond_wb_pipe : directed scenarios plus randomized run against a flag model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cond_wb_pipe;
  localparam int         OPW   = 4;
  localparam int         DEPTH = 3;
  localparam logic [3:0] ADD   = 4'b0000;
  localparam logic [3:0] NAND  = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_wb_pipe_if #(.OPW(OPW)) bus ();

  cond_wb_pipe #(.OPW(OPW), .DEPTH(DEPTH), .ADD_OP(ADD), .NAND_OP(NAND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: list of in-flight instructions, index 0 youngest, plus architectural flags.
  typedef struct packed {
    logic v, wb, cw, zw, c, z;
  } ent_t;
  ent_t mp [DEPTH];
  logic mc, mz;

  function automatic logic m_effc();
    for (int i = 0; i < DEPTH; i++) if (mp[i].v && mp[i].cw) return mp[i].c;
    return mc;
  endfunction

  function automatic logic m_effz();
    for (int i = 0; i < DEPTH; i++) if (mp[i].v && mp[i].zw) return mp[i].z;
    return mz;
  endfunction

  function automatic logic m_sel();
    logic fam;
    fam = (bus.ex_opcode == ADD) || (bus.ex_opcode == NAND);
    return fam && (((bus.ex_funct == 2'b10) && !m_effc()) || ((bus.ex_funct == 2'b01) && !m_effz()));
  endfunction

  function automatic logic m_wbout();
    return bus.ex_valid & bus.ex_wb_in & ~m_sel();
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mp[i] = '0;
    mc = 1'b0;
    mz = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [1:0] fn, input logic wbi,
                        input logic cwr, input logic zwr, input logic cn, input logic zn,
                        input logic ad, input logic fl);
    bus.ex_valid = v;   bus.ex_opcode = op;  bus.ex_funct = fn;  bus.ex_wb_in = wbi;
    bus.ex_c_wr  = cwr; bus.ex_z_wr   = zwr; bus.ex_c_new = cn;  bus.ex_z_new = zn;
    bus.adv      = ad;  bus.flush     = fl;
  endtask

  task automatic idle(input logic ad);
    set_in(1'b0, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ad, 1'b0);
  endtask

  // One clock edge; the model advances from the inputs present before the edge.
  task automatic tick();
    ent_t cur [DEPTH];
    ent_t np  [DEPTH];
    ent_t nw;
    logic s, nc, nz;
    s  = m_sel();
    nc = mc;
    nz = mz;
    cur = mp;
    if (bus.flush) for (int i = 0; i < DEPTH - 1; i++) cur[i].v = 1'b0;
    np = cur;
    if (bus.adv) begin
      if (mp[DEPTH-1].v) begin
        if (mp[DEPTH-1].cw) nc = mp[DEPTH-1].c;
        if (mp[DEPTH-1].zw) nz = mp[DEPTH-1].z;
      end
      for (int i = DEPTH - 1; i > 0; i--) np[i] = cur[i-1];
      nw    = '0;
      if (!bus.flush) begin
        nw.v  = bus.ex_valid;
        nw.wb = bus.ex_valid & bus.ex_wb_in & ~s;
        nw.cw = bus.ex_valid & bus.ex_c_wr & ~s;
        nw.zw = bus.ex_valid & bus.ex_z_wr & ~s;
        nw.c  = bus.ex_c_new;
        nw.z  = bus.ex_z_new;
      end
      np[0] = nw;
    end
    @(posedge clk);
    mp = np;
    mc = nc;
    mz = nz;
    #1;
  endtask

  task automatic do_reset();
    idle(1'b0);
    rst = 1'b1;
    #1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.cm_valid !== 1'b0) begin errors++; $display("FAIL reset_cm_valid got %b exp 0", bus.cm_valid); end
    checks++; if (bus.cm_wb !== 1'b0) begin errors++; $display("FAIL reset_cm_wb got %b exp 0", bus.cm_wb); end
    checks++; if ({bus.c_flag, bus.z_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b exp 00", bus.c_flag, bus.z_flag); end
    checks++; if ({bus.eff_c, bus.eff_z} !== 2'b00) begin errors++; $display("FAIL reset_eff got %b%b exp 00", bus.eff_c, bus.eff_z); end
  endtask

  task automatic test_squash_empty();
    do_reset();
    set_in(1'b1, ADD, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.eff_c !== 1'b0) begin errors++; $display("FAIL sq_eff_c got %b exp 0", bus.eff_c); end
    checks++; if (bus.ex_wb_out !== 1'b0) begin errors++; $display("FAIL sq_wb_out got %b exp 0", bus.ex_wb_out); end
    tick();
    idle(1'b1);
    tick();
    tick();
    checks++; if ({bus.cm_valid, bus.cm_wb} !== 2'b10) begin errors++; $display("FAIL sq_commit_slot got %b%b exp 10", bus.cm_valid, bus.cm_wb); end
    tick();
    checks++; if (bus.c_flag !== 1'b0) begin errors++; $display("FAIL sq_c_flag got %b exp 0", bus.c_flag); end
  endtask

  task automatic test_forward_adc();
    do_reset();
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.ex_wb_out !== 1'b1) begin errors++; $display("FAIL fwd_add_wb got %b exp 1", bus.ex_wb_out); end
    tick();
    set_in(1'b1, ADD, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.eff_c !== 1'b1) begin errors++; $display("FAIL fwd_eff_c got %b exp 1", bus.eff_c); end
    checks++; if (bus.ex_wb_out !== 1'b1) begin errors++; $display("FAIL fwd_adc_wb got %b exp 1", bus.ex_wb_out); end
    tick();
    idle(1'b1);
    tick();
    checks++; if ({bus.cm_valid, bus.cm_wb, bus.c_flag} !== 3'b110) begin errors++; $display("FAIL fwd_pre_commit got %b%b%b exp 110", bus.cm_valid, bus.cm_wb, bus.c_flag); end
    tick();
    checks++; if (bus.c_flag !== 1'b1) begin errors++; $display("FAIL fwd_c_flag got %b exp 1", bus.c_flag); end
  endtask

  task automatic test_no_mask();
    do_reset();
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    // ADZ with Z=0 is squashed; its C write (C=0) must not become visible.
    set_in(1'b1, ADD, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.ex_wb_out !== 1'b0) begin errors++; $display("FAIL nomask_wb got %b exp 0", bus.ex_wb_out); end
    tick();
    idle(1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (bus.eff_c !== 1'b1) begin errors++; $display("FAIL nomask_eff_c cyc %0d got %b exp 1", k, bus.eff_c); end
      tick();
    end
    checks++; if ({bus.c_flag, bus.eff_c} !== 2'b11) begin errors++; $display("FAIL nomask_final got %b%b exp 11", bus.c_flag, bus.eff_c); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, NAND, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    tick();
    checks++; if (bus.eff_z !== 1'b1) begin errors++; $display("FAIL flush_pre_eff_z got %b exp 1", bus.eff_z); end
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.c_flag, bus.z_flag} !== 2'b10) begin errors++; $display("FAIL flush_flags got %b%b exp 10", bus.c_flag, bus.z_flag); end
    checks++; if (bus.cm_valid !== 1'b0) begin errors++; $display("FAIL flush_cm_valid got %b exp 0", bus.cm_valid); end
    set_in(1'b1, NAND, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if ({bus.eff_z, bus.ex_wb_out} !== 2'b00) begin errors++; $display("FAIL flush_ndz got %b%b exp 00", bus.eff_z, bus.ex_wb_out); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, ADD, 2'b00, k[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (bus.ex_wb_out !== k[0]) begin errors++; $display("FAIL stall_wb_track cyc %0d got %b exp %b", k, bus.ex_wb_out, k[0]); end
      checks++; if ({bus.cm_valid, bus.c_flag, bus.eff_c} !== 3'b001) begin errors++; $display("FAIL stall_hold cyc %0d got %b%b%b exp 001", k, bus.cm_valid, bus.c_flag, bus.eff_c); end
      tick();
    end
    idle(1'b1);
    tick();
    checks++; if ({bus.cm_valid, bus.c_flag} !== 2'b10) begin errors++; $display("FAIL stall_resume1 got %b%b exp 10", bus.cm_valid, bus.c_flag); end
    tick();
    checks++; if ({bus.cm_valid, bus.c_flag} !== 2'b01) begin errors++; $display("FAIL stall_resume2 got %b%b exp 01", bus.cm_valid, bus.c_flag); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       op = ADD;
        1:       op = NAND;
        default: op = 4'($urandom);
      endcase
      set_in(1'($urandom), op, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      #1;
      checks++; if (bus.ex_wb_out !== m_wbout()) begin errors++; $display("FAIL rnd_wb_out cyc %0d got %b exp %b", k, bus.ex_wb_out, m_wbout()); end
      checks++; if ({bus.eff_c, bus.eff_z} !== {m_effc(), m_effz()}) begin errors++; $display("FAIL rnd_eff cyc %0d got %b%b exp %b%b", k, bus.eff_c, bus.eff_z, m_effc(), m_effz()); end
      checks++; if ({bus.cm_valid, bus.cm_wb} !== {mp[DEPTH-1].v, mp[DEPTH-1].v & mp[DEPTH-1].wb}) begin errors++; $display("FAIL rnd_commit cyc %0d got %b%b exp %b%b", k, bus.cm_valid, bus.cm_wb, mp[DEPTH-1].v, mp[DEPTH-1].v & mp[DEPTH-1].wb); end
      checks++; if ({bus.c_flag, bus.z_flag} !== {mc, mz}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b%b exp %b%b", k, bus.c_flag, bus.z_flag, mc, mz); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_in(1'b1, ADD, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (DEPTH + 1) tick();
    checks++; if ({bus.cm_valid, bus.c_flag, bus.z_flag} !== 3'b111) begin errors++; $display("FAIL rstmid_pre got %b%b%b exp 111", bus.cm_valid, bus.c_flag, bus.z_flag); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.cm_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cm_valid got %b exp 0", bus.cm_valid); end
    checks++; if ({bus.c_flag, bus.z_flag} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b%b exp 00", bus.c_flag, bus.z_flag); end
    checks++; if ({bus.eff_c, bus.eff_z} !== 2'b00) begin errors++; $display("FAIL rstmid_eff got %b%b exp 00", bus.eff_c, bus.eff_z); end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle(1'b0);
    model_clear();
    test_reset();
    test_squash_empty();
    test_forward_adc();
    test_no_mask();
    test_flush();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
